// File: rtl/ccu_snoop_collector_if.sv
// Snoop collector bus: upstream AC/CR/CD channels plus the per-master fan-out side.
// The slave modport is the collector's view; the master modport is its environment's.
interface ccu_snoop_collector_if #(
  parameter int unsigned NoMst     = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdxW      = (NoMst > 1) ? $clog2(NoMst) : 1
) ();
  logic                       ac_valid_i;
  logic                       ac_ready_o;
  logic [AddrWidth-1:0]       ac_addr_i;
  logic [3:0]                 ac_snoop_i;
  logic [2:0]                 ac_prot_i;
  logic [IdxW-1:0]            init_idx_i;

  logic                       cr_valid_o;
  logic                       cr_ready_i;
  logic [4:0]                 cr_resp_o;

  logic                       cd_valid_o;
  logic                       cd_ready_i;
  logic [DataWidth-1:0]       cd_data_o;
  logic                       cd_last_o;

  logic [NoMst-1:0]           m_ac_valid_o;
  logic [NoMst-1:0]           m_ac_ready_i;
  logic [AddrWidth-1:0]       m_ac_addr_o;
  logic [3:0]                 m_ac_snoop_o;
  logic [2:0]                 m_ac_prot_o;

  logic [NoMst-1:0]           m_cr_valid_i;
  logic [NoMst-1:0]           m_cr_ready_o;
  logic [5*NoMst-1:0]         m_cr_resp_i;

  logic [NoMst-1:0]           m_cd_valid_i;
  logic [NoMst-1:0]           m_cd_ready_o;
  logic [DataWidth*NoMst-1:0] m_cd_data_i;
  logic [NoMst-1:0]           m_cd_last_i;

  modport slave (
    input  ac_valid_i, ac_addr_i, ac_snoop_i, ac_prot_i, init_idx_i,
    output ac_ready_o,
    output cr_valid_o, cr_resp_o,
    input  cr_ready_i,
    output cd_valid_o, cd_data_o, cd_last_o,
    input  cd_ready_i,
    output m_ac_valid_o, m_ac_addr_o, m_ac_snoop_o, m_ac_prot_o,
    input  m_ac_ready_i,
    input  m_cr_valid_i, m_cr_resp_i,
    output m_cr_ready_o,
    input  m_cd_valid_i, m_cd_data_i, m_cd_last_i,
    output m_cd_ready_o
  );

  modport master (
    output ac_valid_i, ac_addr_i, ac_snoop_i, ac_prot_i, init_idx_i,
    input  ac_ready_o,
    input  cr_valid_o, cr_resp_o,
    output cr_ready_i,
    input  cd_valid_o, cd_data_o, cd_last_o,
    output cd_ready_i,
    input  m_ac_valid_o, m_ac_addr_o, m_ac_snoop_o, m_ac_prot_o,
    output m_ac_ready_i,
    output m_cr_valid_i, m_cr_resp_i,
    input  m_cr_ready_o,
    output m_cd_valid_i, m_cd_data_i, m_cd_last_i,
    input  m_cd_ready_o
  );
endinterface

// File: rtl/ccu_snoop_collector.sv
// Broadcasts one snoop to every cached master except the initiator, merges the CR
// responses into one, forwards a single CD burst upstream and drains the others.
module ccu_snoop_collector #(
  parameter int unsigned NoMst     = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdxW      = (NoMst > 1) ? $clog2(NoMst) : 1
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  ccu_snoop_collector_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SNOOP, RESP, DATA} state_e;

  // CRRESP bit positions
  localparam int unsigned DtBit = 0;
  localparam int unsigned ErBit = 1;
  localparam int unsigned PdBit = 2;
  localparam int unsigned IsBit = 3;
  localparam int unsigned WuBit = 4;

  state_e                        state_q;
  logic [AddrWidth-1:0]          addr_q;
  logic [3:0]                    snoop_q;
  logic [2:0]                    prot_q;
  logic [NoMst-1:0]              mask_q, ac_done_q, cr_got_q, cd_done_q, need_q;
  logic [NoMst-1:0][4:0]         resp_q;
  logic [IdxW-1:0]               sel_q;
  logic [4:0]                    cr_resp_q;

  logic [NoMst-1:0][4:0]         resp_in, resp_nx;
  logic [NoMst-1:0][DataWidth-1:0] cd_data_v;
  logic [NoMst-1:0]              onehot, mask_nx;
  logic [NoMst-1:0]              m_ac_valid, m_cr_ready, m_cd_ready;
  logic [NoMst-1:0]              m_ac_hs, m_cr_hs, m_cd_hs;
  logic [NoMst-1:0]              ac_done_nx, cr_got_nx, cd_done_nx;
  logic [NoMst-1:0]              dt_v, need_nx;
  logic [IdxW-1:0]               sel_pd, sel_ok, sel_any, sel_nx;
  logic                          has_pd, has_ok, any_dt, or_is, or_wu;
  logic [4:0]                    merged;
  logic                          ac_hs, snoop_fin, data_fin, in_data;

  assign resp_in   = bus.m_cr_resp_i;
  assign cd_data_v = bus.m_cd_data_i;
  assign in_data   = (state_q == DATA);

  // Upstream AC side
  assign bus.ac_ready_o   = (state_q == IDLE);
  assign ac_hs            = bus.ac_valid_i & bus.ac_ready_o;
  assign bus.m_ac_addr_o  = addr_q;
  assign bus.m_ac_snoop_o = snoop_q;
  assign bus.m_ac_prot_o  = prot_q;

  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    onehot = '0;
    if (int'(bus.init_idx_i) < int'(NoMst)) onehot[bus.init_idx_i] = 1'b1;
    mask_nx = ~onehot;
  end

  // Broadcast and response collection
  assign m_ac_valid       = (state_q == SNOOP) ? (mask_q & ~ac_done_q) : '0;
  assign m_cr_ready       = (state_q == SNOOP) ? (mask_q & ac_done_q & ~cr_got_q) : '0;
  assign bus.m_ac_valid_o = m_ac_valid;
  assign bus.m_cr_ready_o = m_cr_ready;
  assign m_ac_hs          = m_ac_valid & bus.m_ac_ready_i;
  assign m_cr_hs          = m_cr_ready & bus.m_cr_valid_i;
  assign ac_done_nx       = ac_done_q | m_ac_hs;
  assign cr_got_nx        = cr_got_q | m_cr_hs;
  assign snoop_fin        = (state_q == SNOOP) && ((mask_q & ~(ac_done_nx & cr_got_nx)) == '0);

  always_comb begin
    for (int i = 0; i < int'(NoMst); i++) begin
      resp_nx[i] = m_cr_hs[i] ? resp_in[i] : resp_q[i];
    end
  end

  // Merge: descending scan so the last hit in each tier is the lowest index.
  always_comb begin
    sel_pd = '0; sel_ok = '0; sel_any = '0;
    has_pd = 1'b0; has_ok = 1'b0; any_dt = 1'b0;
    or_is  = 1'b0; or_wu  = 1'b0;
    dt_v   = '0;
    for (int i = int'(NoMst) - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        or_is = or_is | resp_nx[i][IsBit];
        or_wu = or_wu | resp_nx[i][WuBit];
        if (resp_nx[i][DtBit]) begin
          dt_v[i] = 1'b1;
          any_dt  = 1'b1;
          sel_any = IdxW'(i);
          if (!resp_nx[i][ErBit]) begin
            has_ok = 1'b1;
            sel_ok = IdxW'(i);
            if (resp_nx[i][PdBit]) begin
              has_pd = 1'b1;
              sel_pd = IdxW'(i);
            end
          end
        end
      end
    end
    sel_nx  = has_pd ? sel_pd : (has_ok ? sel_ok : sel_any);
    need_nx = dt_v;
    merged  = {or_wu, or_is,
               any_dt & resp_nx[sel_nx][PdBit],
               any_dt & resp_nx[sel_nx][ErBit],
               any_dt};
  end

  assign bus.cr_valid_o = (state_q == RESP);
  assign bus.cr_resp_o  = cr_resp_q;

  // Data phase: selected burst goes upstream unregistered, the rest are drained.
  always_comb begin
    m_cd_ready = '0;
    if (in_data) begin
      for (int i = 0; i < int'(NoMst); i++) begin
        if (IdxW'(i) == sel_q) m_cd_ready[i] = bus.cd_ready_i & ~cd_done_q[i];
        else                   m_cd_ready[i] = need_q[i] & ~cd_done_q[i];
      end
    end
  end

  assign bus.m_cd_ready_o = m_cd_ready;
  assign m_cd_hs          = m_cd_ready & bus.m_cd_valid_i;
  assign cd_done_nx       = cd_done_q | (m_cd_hs & bus.m_cd_last_i);
  assign data_fin         = in_data && ((need_q & ~cd_done_nx) == '0);
  assign bus.cd_valid_o   = in_data & bus.m_cd_valid_i[sel_q] & ~cd_done_q[sel_q];
  assign bus.cd_data_o    = in_data ? cd_data_v[sel_q] : '0;
  assign bus.cd_last_o    = in_data & bus.m_cd_last_i[sel_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      snoop_q   <= '0;
      prot_q    <= '0;
      mask_q    <= '0;
      ac_done_q <= '0;
      cr_got_q  <= '0;
      cd_done_q <= '0;
      need_q    <= '0;
      // NOTE: the response array is small and reset with the control state, so a merge never sees X.
      resp_q    <= '0;
      sel_q     <= '0;
      cr_resp_q <= '0;
    end else begin
      // NOTE: non-blocking updates throughout, so every next-state term reads pre-edge values.
      case (state_q)
        IDLE: if (ac_hs) begin
          addr_q    <= bus.ac_addr_i;
          snoop_q   <= bus.ac_snoop_i;
          prot_q    <= bus.ac_prot_i;
          mask_q    <= mask_nx;
          ac_done_q <= '0;
          cr_got_q  <= '0;
          cd_done_q <= '0;
          resp_q    <= '0;
          if (mask_nx == '0) begin
            cr_resp_q <= '0;
            need_q    <= '0;
            state_q   <= RESP;
          end else begin
            state_q   <= SNOOP;
          end
        end
        SNOOP: begin
          ac_done_q <= ac_done_nx;
          cr_got_q  <= cr_got_nx;
          resp_q    <= resp_nx;
          if (snoop_fin) begin
            cr_resp_q <= merged;
            need_q    <= need_nx;
            sel_q     <= sel_nx;
            state_q   <= RESP;
          end
        end
        RESP: if (bus.cr_ready_i) state_q <= (need_q != '0) ? DATA : IDLE;
        DATA: begin
          cd_done_q <= cd_done_nx;
          if (data_fin) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccu_snoop_collector.sv
// Directed bench for ccu_snoop_collector: a cycle-stepped master model answers snoops
// while upstream CR/CD traffic is recorded and compared with hand-computed values.
module tb_ccu_snoop_collector;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  ccu_snoop_collector_if #(.NoMst(4), .AddrWidth(64), .DataWidth(64), .IdxW(2)) bus ();

  ccu_snoop_collector #(.NoMst(4), .AddrWidth(64), .DataWidth(64), .IdxW(2)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Master model configuration and progress
  logic [4:0]  cfg_resp  [4];
  int          cfg_beats [4];
  int          cfg_delay [4];
  bit          got_ac    [4];
  int          ac_hs_cnt [4];
  int          wait_cnt  [4];
  bit          cr_sent   [4];
  int          beat      [4];
  bit          saw_rdy   [4];
  bit          tog_cr, tog_cd;
  int          cyc = 0;

  // Upstream observations
  bit          accepted;
  int          accept_cyc, last_mcr_cyc, first_crv_cyc, cr_cnt;
  logic [3:0]  mav_first;
  logic [4:0]  cr_seen, hold_val;
  bit          hold;
  logic [63:0] cd_data_q[$];
  bit          cd_last_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat_data(input int i, input int b);
    return 64'hD000_0000_0000_0000 | (64'(i) << 16) | 64'(b);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      got_ac[i] = 0; ac_hs_cnt[i] = 0; wait_cnt[i] = 0;
      cr_sent[i] = 0; beat[i] = 0; saw_rdy[i] = 0;
    end
    accepted = 0; accept_cyc = 0; last_mcr_cyc = -1; first_crv_cyc = -1;
    cr_cnt = 0; mav_first = '0; cr_seen = '0; hold = 0; hold_val = '0;
    cd_data_q.delete(); cd_last_q.delete();
  endtask

  task automatic set_cfg(input int i, input logic [4:0] r, input int beats, input int dly);
    cfg_resp[i] = r; cfg_beats[i] = beats; cfg_delay[i] = dly;
  endtask

  task automatic drive_masters();
    for (int i = 0; i < 4; i++) begin
      bus.m_ac_ready_i[i]      = !got_ac[i] && (wait_cnt[i] >= cfg_delay[i]);
      bus.m_cr_valid_i[i]      = got_ac[i] && !cr_sent[i];
      bus.m_cr_resp_i[5*i +: 5] = cfg_resp[i];
      bus.m_cd_valid_i[i]      = cr_sent[i] && cfg_resp[i][0] && (beat[i] < cfg_beats[i]);
      bus.m_cd_data_i[64*i +: 64] = beat_data(i, beat[i]);
      bus.m_cd_last_i[i]       = (beat[i] == cfg_beats[i] - 1);
    end
    bus.cr_ready_i = tog_cr ? (cyc % 2 == 1) : 1'b1;
    bus.cd_ready_i = tog_cd ? (cyc % 3 != 0) : 1'b1;
  endtask

  // Settled mid-cycle view: record the handshakes that the coming edge will take.
  task automatic sample();
    @(negedge clk_i);
    if (bus.ac_valid_i && bus.ac_ready_o && !accepted) begin
      accepted = 1; accept_cyc = cyc;
    end
    if (accepted && cyc == accept_cyc + 1) mav_first = bus.m_ac_valid_o;
    for (int i = 0; i < 4; i++) begin
      if (bus.m_ac_valid_o[i] && bus.m_ac_ready_i[i]) begin
        got_ac[i] = 1; ac_hs_cnt[i]++;
      end else if (bus.m_ac_valid_o[i]) begin
        wait_cnt[i]++;
      end
      if (bus.m_cr_valid_i[i] && bus.m_cr_ready_o[i]) begin
        cr_sent[i] = 1; last_mcr_cyc = cyc;
      end
      if (bus.m_cd_valid_i[i] && bus.m_cd_ready_o[i]) beat[i]++;
      if (bus.m_cd_ready_o[i]) saw_rdy[i] = 1;
    end
    if (bus.cr_valid_o) begin
      if (first_crv_cyc < 0) first_crv_cyc = cyc;
      if (hold) check("cr_stable", 64'(bus.cr_resp_o), 64'(hold_val));
      if (bus.cr_ready_i) begin
        cr_seen = bus.cr_resp_o; cr_cnt++; hold = 0;
      end else begin
        hold = 1; hold_val = bus.cr_resp_o;
      end
    end
    if (bus.cd_valid_o && bus.cd_ready_i) begin
      cd_data_q.push_back(bus.cd_data_o);
      cd_last_q.push_back(bus.cd_last_o);
    end
  endtask

  // Runs one snoop to completion (or until abort_after beats were forwarded).
  task automatic run_snoop(input logic [1:0] init, input logic [63:0] addr, input int abort_after);
    bit done = 0;
    int n = 0;
    clear_model();
    bus.ac_valid_i = 1'b1;
    bus.ac_addr_i  = addr;
    bus.ac_snoop_i = 4'h7;
    bus.ac_prot_i  = 3'h2;
    bus.init_idx_i = init;
    drive_masters();
    while (!done && n < 300) begin
      sample();
      if (accepted && cr_cnt >= 1 && bus.ac_ready_o) done = 1;
      if (abort_after > 0 && cd_data_q.size() >= abort_after) done = 1;
      @(posedge clk_i); #1;
      cyc++; n++;
      if (accepted) bus.ac_valid_i = 1'b0;
      drive_masters();
    end
    check("snoop_done", 64'(done), 64'd1);
  endtask

  task automatic check_burst(input int sel, input int n);
    int got = cd_data_q.size();
    check("cd_count", 64'(got), 64'(n));
    for (int b = 0; b < n && b < got; b++) begin
      check("cd_data", cd_data_q[b], beat_data(sel, b));
      check("cd_last", 64'(cd_last_q[b]), 64'(b == n - 1));
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    tog_cr = 0; tog_cd = 0;
    for (int i = 0; i < 4; i++) set_cfg(i, 5'b00000, 0, 0);
    clear_model();
    bus.ac_valid_i = 1'b0; bus.ac_addr_i = '0; bus.ac_snoop_i = '0;
    bus.ac_prot_i = '0; bus.init_idx_i = '0;
    drive_masters();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ac_ready", 64'(bus.ac_ready_o), 64'd1);
    check("rst_cr_valid", 64'(bus.cr_valid_o), 64'd0);
    check("rst_cd_valid", 64'(bus.cd_valid_o), 64'd0);
    check("rst_m_ac_valid", 64'(bus.m_ac_valid_o), 64'd0);
    check("rst_m_cr_ready", 64'(bus.m_cr_ready_o), 64'd0);
    check("rst_m_cd_ready", 64'(bus.m_cd_ready_o), 64'd0);
    check("rst_m_ac_addr", bus.m_ac_addr_o, 64'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // 1: no data anywhere
    run_snoop(2'd0, 64'h0000_1000_2000_3040, 0);
    check("s1_mav", 64'(mav_first), 64'b1110);
    check("s1_cr", 64'(cr_seen), 64'b00000);
    check("s1_cr_cnt", 64'(cr_cnt), 64'd1);
    check("s1_cr_latency", 64'(first_crv_cyc - last_mcr_cyc), 64'd1);
    check_burst(0, 0);
    check("s1_addr", bus.m_ac_addr_o, 64'h0000_1000_2000_3040);
    check("s1_snoop", 64'(bus.m_ac_snoop_o), 64'h7);
    check("s1_init_no_ac", 64'(ac_hs_cnt[0]), 64'd0);

    // 2: dirty data from m2, shared hint from m3
    set_cfg(1, 5'b00000, 0, 0);
    set_cfg(2, 5'b00101, 4, 0);
    set_cfg(3, 5'b01000, 0, 0);
    run_snoop(2'd0, 64'h0000_0000_0000_0080, 0);
    check("s2_cr", 64'(cr_seen), 64'b01101);
    check_burst(2, 4);

    // 3: two clean data providers, lowest index forwarded, other drained
    set_cfg(1, 5'b00001, 4, 0);
    set_cfg(2, 5'b00000, 0, 0);
    set_cfg(3, 5'b00001, 4, 0);
    run_snoop(2'd0, 64'h0000_0000_0000_00C0, 0);
    check("s3_cr", 64'(cr_seen), 64'b00001);
    check_burst(1, 4);
    check("s3_m3_drain_rdy", 64'(saw_rdy[3]), 64'd1);
    check("s3_m3_drained", 64'(beat[3]), 64'd4);
    check("s3_m2_no_rdy", 64'(saw_rdy[2]), 64'd0);

    // 4: only an erroring data response
    set_cfg(1, 5'b00011, 4, 0);
    set_cfg(3, 5'b00000, 0, 0);
    run_snoop(2'd0, 64'h0000_0000_0000_0100, 0);
    check("s4_cr", 64'(cr_seen), 64'b00011);
    check_burst(1, 4);

    // 5: staggered AC accepts, toggling upstream readies
    set_cfg(1, 5'b00001, 2, 1);
    set_cfg(2, 5'b10101, 3, 3);
    set_cfg(3, 5'b01000, 0, 5);
    tog_cr = 1; tog_cd = 1;
    run_snoop(2'd0, 64'h0000_0000_0000_0140, 0);
    check("s5_cr", 64'(cr_seen), 64'b11101);
    check("s5_cr_cnt", 64'(cr_cnt), 64'd1);
    check("s5_cr_latency", 64'(first_crv_cyc - last_mcr_cyc), 64'd1);
    check_burst(2, 3);
    check("s5_m1_drained", 64'(beat[1]), 64'd2);
    check("s5_ac_once_1", 64'(ac_hs_cnt[1]), 64'd1);
    check("s5_ac_once_2", 64'(ac_hs_cnt[2]), 64'd1);
    check("s5_ac_once_3", 64'(ac_hs_cnt[3]), 64'd1);
    tog_cr = 0; tog_cd = 0;

    // 6: reset during the second forwarded beat, then a fresh snoop
    set_cfg(1, 5'b00000, 0, 0);
    set_cfg(2, 5'b00101, 4, 0);
    set_cfg(3, 5'b00000, 0, 0);
    run_snoop(2'd0, 64'h0000_0000_0000_0180, 1);
    check("s6_mid_data", 64'(bus.cd_valid_o), 64'd1);
    rst_ni = 1'b0;
    clear_model();
    bus.ac_valid_i = 1'b0;
    drive_masters();
    #1;
    check("s6_rst_cd_valid", 64'(bus.cd_valid_o), 64'd0);
    check("s6_rst_m_cd_ready", 64'(bus.m_cd_ready_o), 64'd0);
    check("s6_rst_ac_ready", 64'(bus.ac_ready_o), 64'd1);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    repeat (3) begin
      @(posedge clk_i); #1;
      check("s6_idle_ac_ready", 64'(bus.ac_ready_o), 64'd1);
      check("s6_idle_cr_valid", 64'(bus.cr_valid_o), 64'd0);
      check("s6_idle_m_ac_valid", 64'(bus.m_ac_valid_o), 64'd0);
    end
    set_cfg(0, 5'b01001, 2, 0);
    set_cfg(1, 5'b00000, 0, 0);
    set_cfg(2, 5'b00101, 4, 0);
    set_cfg(3, 5'b00000, 0, 0);
    run_snoop(2'd2, 64'h0000_0000_0000_01C0, 0);
    check("s6_mav", 64'(mav_first), 64'b1011);
    check("s6_cr", 64'(cr_seen), 64'b01001);
    check_burst(0, 2);
    check("s6_init_no_ac", 64'(ac_hs_cnt[2]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
